// File: rtl/hazard_sched.sv
// Hazard scheduler for a 5-stage pipeline: forwarding selects, load/branch/RAW stalls, and a memory wait FSM with timeout.
// Optional forwarding path is built only when HAZARD_FWD_EN is defined; otherwise D-stage RAW hazards stall.

module hs_match (
  input  logic [4:0]      src,
  input  logic [2:0][4:0] wreg,
  input  logic [2:0]      we,
  output logic [2:0]      hit
);
  // hit[0]=E, hit[1]=M, hit[2]=W
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++)
      hit[i] = we[i] && (src != 5'd0) && (src == wreg[i]);
  end
endmodule

module hazard_sched #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MemReqM,
  input  logic       MemAckM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       FlushW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemTimeout
);
  localparam int NUM_SRC = 4;  // 0=RsD 1=RtD 2=RsE 3=RtE
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  logic [NUM_SRC-1:0][4:0] src;
  logic [NUM_SRC-1:0][2:0] hit;
  logic [2:0][4:0]         wreg;
  logic [2:0]              we;

  assign src  = {RtE, RsE, RtD, RsD};
  assign wreg = {WriteRegW, WriteRegM, WriteRegE};
  assign we   = {RegWriteW, RegWriteM, RegWriteE};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
    hs_match u_match (
      .src  (src[g]),
      .wreg (wreg),
      .we   (we),
      .hit  (hit[g])
    );
  end

  logic       dstall;
  logic       fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

`ifdef HAZARD_FWD_EN
  logic lwstall, branchstall;
  // M beats W: it holds the younger value
  assign fwd_ae = hit[2][1] ? 2'b10 : (hit[2][2] ? 2'b01 : 2'b00);
  assign fwd_be = hit[3][1] ? 2'b10 : (hit[3][2] ? 2'b01 : 2'b00);
  assign fwd_ad = hit[0][1];
  assign fwd_bd = hit[1][1];
  assign lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
  assign branchstall = BranchD && (hit[0][0] || hit[1][0] ||
                                   (MemtoRegM && (hit[0][1] || hit[1][1])));
  assign dstall = lwstall || branchstall;
`else
  assign fwd_ae = 2'b00;
  assign fwd_be = 2'b00;
  assign fwd_ad = 1'b0;
  assign fwd_bd = 1'b0;
  // W needs no stall: the register file writes before it is read
  assign dstall = hit[0][0] || hit[0][1] || hit[1][0] || hit[1][1];
`endif

  logic unused_sink;
  assign unused_sink = ^{hit, MemtoRegE, MemtoRegM, BranchD};

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      MemTimeout <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd0;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // ack wins over a coincident timeout
        if (MemAckM) begin
          state_d = RUN;
        end else if (cnt_q == TO_LAST) begin
          state_d = RUN;
          to_d    = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  logic memstall;
  assign memstall = (state_q == MEM_WAIT) || (MemReqM && !MemAckM);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      ForwardAD = fwd_ad;
      ForwardBD = fwd_bd;
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = dstall;
        StallD = dstall;
        FlushE = dstall;
      end
    end
  end
endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: stimulus pushes model expectations, a negedge monitor pops and compares.

module tb_hazard_sched;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [4:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0;
  logic [4:0] WriteRegE = '0, WriteRegM = '0, WriteRegW = '0;
  logic       RegWriteE = 0, RegWriteM = 0, RegWriteW = 0;
  logic       MemtoRegE = 0, MemtoRegM = 0, BranchD = 0, MemReqM = 0, MemAckM = 0;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD, MemTimeout;
  logic [1:0] ForwardAE, ForwardBE;

  hazard_sched #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout)
  );

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, rwm, rww, mte, mtm, br, req, ack;
  } vec_t;

  // {StallF,StallD,StallE,StallM,FlushE,FlushW,ForwardAD,ForwardBD,ForwardAE,ForwardBE,MemTimeout}
  logic [12:0] expq[$];
  int vectors = 0, miscompares = 0;

  // model: are we waiting on memory, how many wait cycles have elapsed, timeout pulse pending
  bit m_wait = 0;
  int m_waited = 0;
  bit m_to = 0;

  function automatic bit mt(input logic [4:0] s, input logic [4:0] w, input logic e);
    return e && (s != 5'd0) && (s == w);
  endfunction

  task automatic drive(input vec_t v);
    logic [1:0] ae, be;
    logic ad, bd, ds, ms;
    logic [12:0] e;
    @(posedge clk); #1;
    rst_n = v.rst_n; RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    MemtoRegE = v.mte; MemtoRegM = v.mtm; BranchD = v.br; MemReqM = v.req; MemAckM = v.ack;
`ifdef HAZARD_FWD_EN
    ae = mt(v.rse, v.wrm, v.rwm) ? 2'd2 : (mt(v.rse, v.wrw, v.rww) ? 2'd1 : 2'd0);
    be = mt(v.rte, v.wrm, v.rwm) ? 2'd2 : (mt(v.rte, v.wrw, v.rww) ? 2'd1 : 2'd0);
    ad = mt(v.rsd, v.wrm, v.rwm);
    bd = mt(v.rtd, v.wrm, v.rwm);
    ds = (v.mte && v.rte != 0 && (v.rte == v.rsd || v.rte == v.rtd)) ||
         (v.br && (mt(v.rsd, v.wre, v.rwe) || mt(v.rtd, v.wre, v.rwe) ||
                   (v.mtm && (mt(v.rsd, v.wrm, v.rwm) || mt(v.rtd, v.wrm, v.rwm)))));
`else
    ae = 2'd0; be = 2'd0; ad = 0; bd = 0;
    ds = mt(v.rsd, v.wre, v.rwe) || mt(v.rtd, v.wre, v.rwe) ||
         mt(v.rsd, v.wrm, v.rwm) || mt(v.rtd, v.wrm, v.rwm);
`endif
    ms = m_wait || (v.req && !v.ack);
    if (!v.rst_n)  e = {12'b0, m_to};
    else if (ms)   e = {6'b111101, ad, bd, ae, be, m_to};
    else           e = {ds, ds, 1'b0, 1'b0, ds, 1'b0, ad, bd, ae, be, m_to};
    expq.push_back(e);
    if (!v.rst_n) begin
      m_wait = 0; m_waited = 0; m_to = 0;
    end else if (!m_wait) begin
      m_to = 0;
      if (v.req && !v.ack) begin m_wait = 1; m_waited = 0; end
    end else begin
      m_waited++;
      m_to = 0;
      if (v.ack) m_wait = 0;
      else if (m_waited == TO) begin m_wait = 0; m_to = 1; end
    end
  endtask

  initial forever begin
    logic [12:0] e, a;
    @(negedge clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MemTimeout};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d outputs got=%b want=%b (SF SD SE SM FE FW AD BD AE BE TO)",
                 vectors, a, e);
      end
    end
  end

  initial begin
    vec_t v;
    v = '0;
    drive(v); drive(v);
    v.rst_n = 1;
    drive(v);
    // M/W forwarding priority, then W only
    v.rwm = 1; v.wrm = 8; v.rse = 8; v.rww = 1; v.wrw = 8;
    drive(v);
    v.rwm = 0;
    drive(v);
    // load-use stall and $zero never matching
    v = '0; v.rst_n = 1; v.mte = 1; v.rte = 9; v.rsd = 9;
    drive(v);
    v = '0; v.rst_n = 1; v.rwm = 1; v.wrm = 0; v.rse = 0; v.rsd = 0;
    drive(v);
    // three-cycle memory wait then ack
    v = '0; v.rst_n = 1; v.req = 1;
    repeat (3) drive(v);
    v.ack = 1; drive(v);
    v = '0; v.rst_n = 1; drive(v);
    // never acked: timeout
    v.req = 1;
    repeat (TO + 1) drive(v);
    v.req = 0; drive(v); drive(v);
    // reset mid-wait
    v.req = 1; drive(v); drive(v);
    v.rst_n = 0; drive(v);
    v.rst_n = 1; v.req = 0; drive(v); drive(v);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v.rst_n = ($urandom_range(0, 59) != 0);
      v.rsd = 5'($urandom_range(0, 3)); v.rtd = 5'($urandom_range(0, 3));
      v.rse = 5'($urandom_range(0, 3)); v.rte = 5'($urandom_range(0, 3));
      v.wre = 5'($urandom_range(0, 3)); v.wrm = 5'($urandom_range(0, 3));
      v.wrw = 5'($urandom_range(0, 3));
      v.rwe = 1'($urandom); v.rwm = 1'($urandom); v.rww = 1'($urandom);
      v.mte = 1'($urandom); v.mtm = 1'($urandom); v.br = 1'($urandom);
      v.req = ($urandom_range(0, 2) == 0);
      v.ack = ($urandom_range(0, 5) == 0);
      drive(v);
    end
    @(negedge clk); #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 RsD, RtD  in  5 each  source register numbers of the instruction in Decode.
REQ-004 RsE, RtE  in  5 each  source register numbers of the instruction in Execute.
REQ-005 WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register numbers in E/M/W.
REQ-006 RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enable in E/M/W.
REQ-007 MemtoRegE, MemtoRegM  in  1 each  load instruction in E/M.
REQ-008 BranchD  in  1  branch decoded in D (compare happens in D).
REQ-009 MemReqM  in  1  data-memory access (lw/sw) in M.
REQ-010 MemAckM  in  1  data memory has completed the access this cycle.
REQ-011 StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register feeding that stage.
REQ-012 FlushE, FlushW  out  1 each  load a bubble into E / W.
REQ-013 ForwardAD, ForwardBD  out  1 each  1 selects ALUOutM for the D-stage compare operand.
REQ-014 ForwardAE, ForwardBE  out  2 each  00 register file, 01 ResultW, 10 ALUOutM.
REQ-015 MemTimeout  out  1  one-cycle pulse when a memory wait is abandoned.
REQ-016 Parameter MEM_TIMEOUT, default 64, range 1..255: maximum wait cycles per access.

Function
REQ-017 A register match SHALL require matching numbers, source register nonzero and the writer's RegWrite asserted.
REQ-018 ForwardAE SHALL be 10 on M match with RsE, else 01 on W match, else 00; ForwardBE likewise on RtE; M has priority.
REQ-019 ForwardAD/BD SHALL be 1 on M match with RsD/RtD.
REQ-020 lwstall SHALL be MemtoRegE and RtE equal to RsD or RtD (RtE nonzero).
REQ-021 branchstall SHALL be BranchD and (E match on RsD/RtD, or MemtoRegM and M match on RsD/RtD).
REQ-022 FSM states: RUN, MEM_WAIT; 8-bit wait counter.
REQ-023 RUN: MemReqM and not MemAckM SHALL go to MEM_WAIT with counter cleared; MemReqM with MemAckM in the same cycle SHALL produce no stall.
REQ-024 MEM_WAIT: counter SHALL increment each cycle; MemAckM SHALL return to RUN.
REQ-025 MEM_WAIT with no ack when counter equals MEM_TIMEOUT-1 SHALL return to RUN and register MemTimeout high for exactly the next cycle.
REQ-026 memstall = MEM_WAIT or (RUN and MemReqM and not MemAckM); while memstall, StallF/D/E/M and FlushW SHALL be 1 and FlushE 0 (memstall overrides lwstall/branchstall).
REQ-027 Otherwise StallF = StallD = FlushE = lwstall or branchstall; StallE, StallM, FlushW 0.
REQ-028 Simultaneous ack and timeout in the same cycle SHALL count as ack (no MemTimeout).

Reset
REQ-029 rst_n low at a clock edge SHALL set state RUN, counter 0, MemTimeout 0, including mid-wait.
REQ-030 While rst_n is low, all stall, flush and forward outputs SHALL be 0.

Configuration
REQ-031 HAZARD_FWD_EN defined: forwarding per REQ-018/019, stalls per REQ-020/021.
REQ-032 HAZARD_FWD_EN undefined: all Forward outputs 0; lwstall/branchstall replaced by a D-stage RAW stall on any E or M match with RsD/RtD (W covered by write-first register file).

Verification
REQ-033 RegWriteM=1, WriteRegM=8, RsE=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=10; clear RegWriteM -> 01.
REQ-034 MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1 for one cycle; WriteRegM=0 match never forwards.
REQ-035 MemReqM=1, MemAckM low 3 cycles then high -> StallF..StallM=1 and FlushW=1 for 3 cycles, RUN on 4th, MemTimeout 0.
REQ-036 MEM_TIMEOUT=4, MemAckM never -> stalls for 4 cycles, MemTimeout pulses once, state RUN.
REQ-037 rst_n low 1 cycle during MEM_WAIT -> next cycle RUN, all outputs 0 during reset, counter 0.
